itype_stim_sequencer: RTL and testbench
=======================================

# itype_stim_sequencer

Synthesizable instruction-stream sequencer that drives the sodor5 instruction-memory response port with pseudo-random RV32I I-type ALU instructions (ADDI/SLTI/SLTIU/XORI/ORI/ANDI/SLLI/SRLI/SRAI). It replaces the behavioural random-instruction process in the verification harness so that the reference model and the core are fed by one deterministic, reproducible stream. It sits between the harness control (start/done) and the core's `imem_resp_bits_data` input. After each run it inserts a NOP drain so that every issued instruction retires.

## Interface
Parameters:
- `NUM_INSTRS`, 64: number of random instructions issued per run; must be ≥ 1.
- `DRAIN_CYCLES`, 5: number of NOP transfers after the last random instruction; may be 0.
- `SEED`, 32'h0000_0209: initial LFSR state; a value of 0 is replaced by 32'h1.

Ports:
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: single-cycle pulse; ignored unless the FSM is in IDLE or DONE.
- `instr_ready` in 1: core/imem accepts the word this cycle.
- `instr_valid` out 1: `instr` is offered.
- `instr` out 32: instruction word; 32'h0000_0013 (NOP) whenever no random instruction is offered.
- `issued_cnt` out 16: count of random instructions transferred in the current run.
- `busy` out 1: FSM is in ISSUE or DRAIN.
- `done` out 1: high in DONE; sticky until the next `start`.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- Transitions:
  - IDLE or DONE + `start` → ISSUE; this also clears `issued_cnt` and the drain counter.
  - ISSUE → DRAIN on the transfer that brings `issued_cnt` to `NUM_INSTRS`. If `DRAIN_CYCLES` = 0, the target is DONE instead.
  - DRAIN → DONE on the transfer that brings the drain count to `DRAIN_CYCLES`.
- Transfer rule: a transfer occurs when `instr_valid & instr_ready` on a rising edge.
- `instr_valid` behaviour per state:
  - IDLE and DONE: low, `instr` = NOP.
  - ISSUE: high, `instr` = random word.
  - DRAIN: high, `instr` = NOP.
- LFSR:
  - 32-bit Galois, right shift: next = lsb ? (s>>1) ^ 32'h8020_0003 : s>>1.
  - Advances only on a transfer in ISSUE. The state is not reseeded by `start`, so back-to-back runs continue the sequence.
- Field map from current LFSR state `s`:
  - imm = s[31:20], rs1 = s[19:15], funct3 = s[14:12], rd = s[11:7].
  - instr = {imm', rs1, funct3, rd, 7'b0010011}.
- Shift immediate masking:
  - funct3 = 3'b001: imm' = imm & 12'h01F.
  - funct3 = 3'b101: imm' = imm & 12'h41F, which keeps the SRAI bit 10.
  - otherwise: imm' = imm.
- `issued_cnt` saturates at 16'hFFFF. It does not wrap.

## Timing
- Reset values: FSM = IDLE, LFSR = SEED (or 1 if SEED is 0), `instr_valid` = 0, `instr` = 32'h13, `issued_cnt` = 0, `busy` = 0, `done` = 0.
- All outputs are registered; there is no combinational path from `instr_ready` to any output.
- `start` at edge N: `instr_valid` = 1 with the first random word after edge N (one-cycle latency).
- Stall hold: while `instr_valid & !instr_ready`, `instr` and LFSR are held stable (AXI-style hold rule).
- `start` asserted during ISSUE or DRAIN is ignored. The run is not restarted.
- Deasserting `reset_n` mid-run aborts immediately to reset values. No partial drain is performed.
- Minimum run length with `instr_ready` held at 1: NUM_INSTRS + DRAIN_CYCLES cycles of `busy`, then `done` on the following cycle.

## Structure
- Shared package `sodor_stim_pkg`:
  - state enum.
  - `OPC_OP_IMM` = 7'b0010011.
  - `INSTR_NOP` = 32'h0000_0013.
  - `LFSR_TAPS` = 32'h8020_0003.
  - funct3 constants `F3_SLLI` and `F3_SRLI_SRAI`.
- One sub-module `stim_lfsr32` (state, enable, seed load), instantiated once.
- Field packing and masking are combinational logic in the top module.

## Test plan
- Reset default: reset, then hold with no `start` for 10 cycles → `instr_valid` = 0, `instr` = 32'h13, `done` = 0.
- Seed and step check: SEED default, `start`, `instr_ready` = 1 → first word 32'h0000_0213, second word 32'h8020_0113.
- Backpressure: hold `instr_ready` = 0 for 4 cycles mid-ISSUE → `instr` unchanged for all 4 cycles, `issued_cnt` unchanged, and the stream resumes with the identical next word.
- Masking: 10,000 words, scoreboarding each → every funct3 = 001 word has bits[31:25] = 0, and every funct3 = 101 word has bits[31:25] ∈ {0, 7'b0100000}.
- Run shape: `NUM_INSTRS` = 3, `DRAIN_CYCLES` = 5, ready always 1 → exactly 3 random words, then 5 NOPs, then `done` = 1. `start` during the run is ignored. A second `start` yields the 4th LFSR word first.
- Abort: assert `reset_n` low in DRAIN → all outputs return to reset values asynchronously, and the next run begins from the SEED word 32'h0000_0213.

Source files
------------

// File: rtl/sodor_stim_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sodor_stim_pkg
//  Description : Shared types and constants for the I-type stimulus sequencer
//                (state encoding, opcode, NOP word, LFSR taps, funct3 codes).
//  Revision    : 1.0 - initial release
// ============================================================================
package sodor_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [6:0]  OPC_OP_IMM   = 7'b0010011;
    localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;

    // Shift-immediate funct3 codes that need immediate masking
    localparam logic [2:0]  F3_SLLI      = 3'b001;
    localparam logic [2:0]  F3_SRLI_SRAI = 3'b101;

endpackage : sodor_stim_pkg
`default_nettype wire

// File: rtl/stim_lfsr32.sv
`default_nettype none
// ============================================================================
//  Module      : stim_lfsr32
//  Description : 32-bit right-shifting Galois LFSR with enable and synchronous
//                seed load. A zero seed is replaced by 1 so the register can
//                never lock up in the all-zero state.
//  Revision    : 1.0 - initial release
// ============================================================================
module stim_lfsr32
    import sodor_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0209
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en_i,
    input  logic        load_i,
    output logic [31:0] state_o,
    output logic [31:0] next_o
);

    localparam logic [31:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

    logic [31:0] state_q;

    // Next value is exposed so the owner can look one step ahead on a transfer
    assign next_o  = state_q[0] ? ((state_q >> 1) ^ LFSR_TAPS) : (state_q >> 1);
    assign state_o = state_q;

    // State register: seed on reset or load, step only when enabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SEED_EFF;
        end else if (load_i) begin
            state_q <= SEED_EFF;
        end else if (en_i) begin
            state_q <= next_o;
        end
    end

endmodule : stim_lfsr32
`default_nettype wire

// File: rtl/itype_stim_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : itype_stim_sequencer
//  Description : Feeds the instruction-memory response port with a
//                reproducible stream of random RV32I I-type ALU instructions,
//                followed by a NOP drain so every issued word retires.
//  Revision    : 1.0 - initial release
// ============================================================================
module itype_stim_sequencer
    import sodor_stim_pkg::*;
#(
    parameter int unsigned NUM_INSTRS   = 64,
    parameter int unsigned DRAIN_CYCLES = 5,
    parameter logic [31:0] SEED         = 32'h0000_0209
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        instr_ready,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [15:0] issued_cnt,
    output logic        busy,
    output logic        done
);

    seq_state_e  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [31:0] drain_q, drain_d;
    logic [31:0] instr_q, instr_d;

    logic        offering_w;
    logic        xfer_w;
    logic        lfsr_en_w;
    logic [31:0] lfsr_state_w;
    logic [31:0] lfsr_next_w;
    logic [31:0] lfsr_view_w;
    logic [31:0] cnt_inc_w;
    logic [31:0] drain_inc_w;
    logic [11:0] imm_w;
    logic [2:0]  f3_w;
    logic [31:0] word_w;

    assign offering_w  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign xfer_w      = offering_w && instr_ready;
    // The LFSR only moves when a random word is actually accepted, so a
    // stalled word stays stable until the core takes it
    assign lfsr_en_w   = (state_q == ST_ISSUE) && instr_ready;
    assign lfsr_view_w = lfsr_en_w ? lfsr_next_w : lfsr_state_w;
    assign cnt_inc_w   = {16'd0, cnt_q} + 32'd1;
    assign drain_inc_w = drain_q + 32'd1;

    stim_lfsr32 #(
        .SEED    (SEED)
    ) u_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .en_i    (lfsr_en_w),
        .load_i  (1'b0),
        .state_o (lfsr_state_w),
        .next_o  (lfsr_next_w)
    );

    // Pack the LFSR state that will be current after this edge into an
    // I-type word; shift forms keep only shamt (plus the SRAI select bit)
    always_comb begin
        f3_w  = lfsr_view_w[14:12];
        imm_w = lfsr_view_w[31:20];
        if (f3_w == F3_SLLI) begin
            imm_w = lfsr_view_w[31:20] & 12'h01F;
        end else if (f3_w == F3_SRLI_SRAI) begin
            imm_w = lfsr_view_w[31:20] & 12'h41F;
        end
        word_w = {imm_w, lfsr_view_w[19:15], f3_w, lfsr_view_w[11:7], OPC_OP_IMM};
    end

    // Next-state, counters and the registered instruction word
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    cnt_d   = 16'd0;
                    drain_d = 32'd0;
                end
            end
            ST_ISSUE: begin
                if (xfer_w) begin
                    if (cnt_q != 16'hFFFF) begin
                        cnt_d = cnt_q + 16'd1;
                    end
                    if (cnt_inc_w == NUM_INSTRS) begin
                        state_d = (DRAIN_CYCLES == 0) ? ST_DONE : ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (xfer_w) begin
                    drain_d = drain_inc_w;
                    if (drain_inc_w == DRAIN_CYCLES) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        instr_d = (state_d == ST_ISSUE) ? word_w : INSTR_NOP;
    end

    // State and datapath registers; reset aborts any run immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            drain_q <= 32'd0;
            instr_q <= INSTR_NOP;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            drain_q <= drain_d;
            instr_q <= instr_d;
        end
    end

    // Outputs are decodes of flops only; nothing depends on instr_ready here
    assign instr_valid = offering_w;
    assign busy        = offering_w;
    assign done        = (state_q == ST_DONE);
    assign instr       = instr_q;
    assign issued_cnt  = cnt_q;

endmodule : itype_stim_sequencer
`default_nettype wire

// File: tb/tb_itype_stim_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_itype_stim_sequencer
//  Description : Self-checking bench for itype_stim_sequencer with a
//                run-level behavioural model and randomized handshaking.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_itype_stim_sequencer;

    localparam int unsigned NUM   = 3;
    localparam int unsigned DRAIN = 5;
    localparam logic [31:0] SEED  = 32'h0000_0209;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] TAPS  = 32'h8020_0003;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        instr_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [15:0] issued_cnt;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_words = 0;
    bit rec_en = 0;
    logic [31:0] rec_q[$];

    // Model state: the LFSR value behind the word currently offered, and
    // how many random / NOP transfers remain in the current run
    logic [31:0] m_s;
    bit          m_running;
    bit          m_done;
    int          m_words_left;
    int          m_drain_left;
    int          m_cnt;

    itype_stim_sequencer #(
        .NUM_INSTRS   (NUM),
        .DRAIN_CYCLES (DRAIN),
        .SEED         (SEED)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .issued_cnt  (issued_cnt),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = s / 2;
        if ((s % 2) == 1) r = r ^ TAPS;
        return r;
    endfunction

    function automatic logic [31:0] mdl_word(input logic [31:0] s);
        int unsigned imm, rs1, f3, rd;
        imm = s / 1048576;
        rs1 = (s / 32768) % 32;
        f3  = (s / 4096) % 8;
        rd  = (s / 128) % 32;
        if (f3 == 1)      imm = imm % 32;
        else if (f3 == 5) imm = imm % 32 + ((imm / 1024) % 2) * 1024;
        return 32'(imm * 1048576 + rs1 * 32768 + f3 * 4096 + rd * 128 + 19);
    endfunction

    // Behavioural model: advances one run step per accepted transfer
    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_s = SEED; m_running = 0; m_done = 0;
                m_words_left = 0; m_drain_left = 0; m_cnt = 0;
            end else if (!m_running) begin
                if (start) begin
                    m_running = 1; m_done = 0; m_cnt = 0;
                    m_words_left = NUM; m_drain_left = DRAIN;
                end
            end else if (instr_ready) begin
                if (m_words_left > 0) begin
                    m_words_left--;
                    if (m_cnt < 65535) m_cnt++;
                    m_s = lfsr_step(m_s);
                end else begin
                    m_drain_left--;
                end
                if (m_words_left == 0 && m_drain_left == 0) begin
                    m_running = 0; m_done = 1;
                end
            end
        end
    end

    // Compare process: every falling edge, DUT outputs against the model
    initial begin
        logic [31:0] exp_instr;
        forever begin
            @(negedge clk);
            exp_instr = (m_running && m_words_left > 0) ? mdl_word(m_s) : NOP;
            chk("valid", instr_valid, m_running);
            chk("busy",  busy,        m_running);
            chk("done",  done,        m_done);
            chk("instr", instr,       exp_instr);
            chk("cnt",   issued_cnt,  m_cnt);
            if (instr_valid && instr_ready) begin
                if (rec_en) rec_q.push_back(instr);
                if (m_running && m_words_left > 0) begin
                    n_words++;
                    if (instr[14:12] == 3'b001)
                        chk("mask_slli", instr[31:25], 32'd0);
                    else if (instr[14:12] == 3'b101)
                        chk("mask_srxi", (instr[31:25] == 7'd0) || (instr[31:25] == 7'b0100000), 32'd1);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!done && k < budget) begin
            cyc();
            k++;
        end
        chk("done_in_budget", done, 32'd1);
    endtask

    initial begin
        int busy_cycles;
        int guard;
        logic [31:0] w;
        logic [15:0] c;

        reset_n = 1'b0; start = 1'b0; instr_ready = 1'b1;
        repeat (3) cyc();
        reset_n = 1'b1;

        // Idle with no start: nothing offered
        repeat (10) cyc();
        chk("idle_valid", instr_valid, 32'd0);
        chk("idle_instr", instr, NOP);
        chk("idle_done",  done, 32'd0);
        chk("idle_busy",  busy, 32'd0);

        // Run 1: full-speed run, stray start mid-run must be ignored
        rec_q.delete();
        rec_en = 1'b1;
        pulse_start();
        busy_cycles = busy ? 1 : 0;
        guard = 0;
        while (!done && guard < 40) begin
            start = (busy_cycles == 4);
            cyc();
            if (busy) busy_cycles++;
            guard++;
        end
        start = 1'b0;
        rec_en = 1'b0;
        chk("run1_done", done, 32'd1);
        chk("run1_busy_cycles", busy_cycles, 32'd8);
        chk("run1_xfers", rec_q.size(), 32'd8);
        if (rec_q.size() == 8) begin
            chk("run1_w0", rec_q[0], 32'h0000_0213);
            chk("run1_w1", rec_q[1], 32'h8020_0113);
            chk("run1_w2", rec_q[2], 32'hC030_0093);
            for (int i = 3; i < 8; i++) chk("run1_nop", rec_q[i], NOP);
        end
        chk("run1_cnt", issued_cnt, 32'd3);

        // Run 2: continues the sequence, then a 4-cycle stall
        pulse_start();
        chk("run2_first", instr, 32'h6018_0013);
        cyc();
        instr_ready = 1'b0;
        w = instr;
        c = issued_cnt;
        chk("run2_second", w, 32'h300C_0013);
        chk("run2_cnt_pre", c, 32'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("stall_instr", instr, w);
            chk("stall_cnt", issued_cnt, 32'd1);
            chk("stall_valid", instr_valid, 32'd1);
        end
        instr_ready = 1'b1;
        cyc();
        chk("resume_cnt", issued_cnt, 32'd2);
        wait_done(40);

        // Abort in DRAIN, then a fresh run restarts from the seed word
        pulse_start();
        guard = 0;
        while (!(busy && issued_cnt == 16'd3) && guard < 40) begin
            cyc();
            guard++;
        end
        chk("reached_drain", busy && issued_cnt == 16'd3, 32'd1);
        cyc();
        #1 reset_n = 1'b0;
        #1;
        chk("abort_valid", instr_valid, 32'd0);
        chk("abort_instr", instr, NOP);
        chk("abort_cnt",   issued_cnt, 32'd0);
        chk("abort_busy",  busy, 32'd0);
        chk("abort_done",  done, 32'd0);
        cyc();
        reset_n = 1'b1;
        cyc();
        pulse_start();
        chk("restart_first", instr, 32'h0000_0213);
        wait_done(40);

        // Randomized handshaking and stray starts over many runs
        guard = 0;
        while (n_words < 10000 && guard < 80000) begin
            instr_ready = ($urandom_range(0, 3) != 0);
            start = done ? 1'b1 : ($urandom_range(0, 15) == 0);
            cyc();
            guard++;
        end
        start = 1'b0;
        instr_ready = 1'b1;
        chk("random_words_reached", n_words >= 10000, 32'd1);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_itype_stim_sequencer
`default_nettype wire
